// File: rtl/syspe_stream_feeder.sv
// Transmit side of the SysPE weight/act/accum vld-busy streams, fed from two host-loaded RAMs.
// Optional stall counter port enabled by defining SYSPE_FEEDER_STALL_CNT_EN.
module syspe_stream_feeder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACCW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic [AW:0]     len,
    input  logic [ACCW-1:0] bias,
    output logic            active,
    output logic            done,
    input  logic            weight_out_busy,
    output logic            weight_out_vld,
    output logic [DW-1:0]   weight_out_data,
    input  logic            act_out_busy,
    output logic            act_out_vld,
    output logic [DW-1:0]   act_out_data,
    input  logic            accum_out_busy,
    output logic            accum_out_vld,
`ifdef SYSPE_FEEDER_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic [ACCW-1:0] accum_out_data
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic [AW:0]     len_q, len_d;

    logic [DW-1:0]   wram_q [DEPTH];
    logic [DW-1:0]   aram_q [DEPTH];

    logic            w_vld_q, w_vld_d, a_vld_q, a_vld_d, c_vld_q, c_vld_d;
    logic [DW-1:0]   w_data_q, w_data_d, a_data_q, a_data_d;
    logic [ACCW-1:0] c_data_q, c_data_d;
    logic [AW:0]     w_idx_q, w_idx_d, a_idx_q, a_idx_d, c_idx_q, c_idx_d;
    logic [AW:0]     w_nxt, a_nxt, c_nxt;
    logic            accept;

    assign w_nxt = w_idx_q + (AW+1)'(1);
    assign a_nxt = a_idx_q + (AW+1)'(1);
    assign c_nxt = c_idx_q + (AW+1)'(1);

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        len_d    = len_q;
        accept   = 1'b0;
        w_vld_d  = w_vld_q;
        a_vld_d  = a_vld_q;
        c_vld_d  = c_vld_q;
        w_data_d = w_data_q;
        a_data_d = a_data_q;
        c_data_d = c_data_q;
        w_idx_d  = w_idx_q;
        a_idx_d  = a_idx_q;
        c_idx_d  = c_idx_q;
        unique case (state_q)
            StIdle: begin
                // done_q high means the previous burst ended this cycle; start is ignored
                if (start && !done_q) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        len_d    = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
                        state_d  = StRun;
                        w_vld_d  = 1'b1;
                        a_vld_d  = 1'b1;
                        c_vld_d  = 1'b1;
                        w_data_d = wram_q[0];
                        a_data_d = aram_q[0];
                        c_data_d = bias;
                        w_idx_d  = '0;
                        a_idx_d  = '0;
                        c_idx_d  = '0;
                    end
                end
            end
            StRun: begin
                if (w_vld_q && !weight_out_busy) begin
                    w_idx_d = w_nxt;
                    if (w_nxt < len_q) begin
                        w_data_d = wram_q[w_nxt[AW-1:0]];
                    end else begin
                        w_vld_d = 1'b0;
                    end
                end
                if (a_vld_q && !act_out_busy) begin
                    a_idx_d = a_nxt;
                    if (a_nxt < len_q) begin
                        a_data_d = aram_q[a_nxt[AW-1:0]];
                    end else begin
                        a_vld_d = 1'b0;
                    end
                end
                if (c_vld_q && !accum_out_busy) begin
                    c_idx_d = c_nxt;
                    if (c_nxt >= len_q) begin
                        c_vld_d = 1'b0;
                    end
                end
                // Look at post-transfer counts so done appears the cycle after the last token
                if (w_idx_d == len_q && a_idx_d == len_q && c_idx_d == len_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            done_q   <= 1'b0;
            len_q    <= '0;
            w_vld_q  <= 1'b0;
            a_vld_q  <= 1'b0;
            c_vld_q  <= 1'b0;
            w_data_q <= '0;
            a_data_q <= '0;
            c_data_q <= '0;
            w_idx_q  <= '0;
            a_idx_q  <= '0;
            c_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            len_q    <= len_d;
            w_vld_q  <= w_vld_d;
            a_vld_q  <= a_vld_d;
            c_vld_q  <= c_vld_d;
            w_data_q <= w_data_d;
            a_data_q <= a_data_d;
            c_data_q <= c_data_d;
            w_idx_q  <= w_idx_d;
            a_idx_q  <= a_idx_d;
            c_idx_q  <= c_idx_d;
        end
    end

    // RAM has no reset; contents survive a reset but are not relied upon
    always_ff @(posedge clk) begin
        if (state_q == StIdle && wr_en) begin
            if (wr_sel) begin
                aram_q[wr_addr] <= wr_data;
            end else begin
                wram_q[wr_addr] <= wr_data;
            end
        end
    end

`ifdef SYSPE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (state_q == StRun && stall_q != 16'hFFFF &&
                     ((w_vld_q && weight_out_busy) || (a_vld_q && act_out_busy) ||
                      (c_vld_q && accum_out_busy))) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign active          = (state_q != StIdle);
    assign done            = done_q;
    assign weight_out_vld  = w_vld_q;
    assign weight_out_data = w_data_q;
    assign act_out_vld     = a_vld_q;
    assign act_out_data    = a_data_q;
    assign accum_out_vld   = c_vld_q;
    assign accum_out_data  = c_data_q;

endmodule

// File: tb/tb_syspe_stream_feeder.sv
// Directed self-checking bench for syspe_stream_feeder (inputs driven #1 after posedge,
// outputs sampled on negedge).
module tb_syspe_stream_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int ACCW  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0, wr_sel = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            start = 1'b0;
    logic [AW:0]     len = '0;
    logic [ACCW-1:0] bias = '0;
    logic            active, done;
    logic            weight_out_busy = 1'b0, act_out_busy = 1'b0, accum_out_busy = 1'b0;
    logic            weight_out_vld, act_out_vld, accum_out_vld;
    logic [DW-1:0]   weight_out_data, act_out_data;
    logic [ACCW-1:0] accum_out_data;
`ifdef SYSPE_FEEDER_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] w_tok [32];
    logic [31:0] a_tok [32];
    logic [31:0] c_tok [32];
    logic [31:0] w_exp [32];
    logic [31:0] a_exp [32];
    int w_n, a_n, c_n;

    always #5 clk = ~clk;

    syspe_stream_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .start           (start),
        .len             (len),
        .bias            (bias),
        .active          (active),
        .done            (done),
        .weight_out_busy (weight_out_busy),
        .weight_out_vld  (weight_out_vld),
        .weight_out_data (weight_out_data),
        .act_out_busy    (act_out_busy),
        .act_out_vld     (act_out_vld),
        .act_out_data    (act_out_data),
        .accum_out_busy  (accum_out_busy),
        .accum_out_vld   (accum_out_vld),
`ifdef SYSPE_FEEDER_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .accum_out_data  (accum_out_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    // Issues start then runs cycle by cycle; act is stalled in cycles st_from..st_to.
    // In cycle inj a host write WRAM[1]=99 and a second start are driven.
    task automatic run_burst(input int ln, input int bs, input int st_from, input int st_to,
                             input int stall_act, input int inj, output int done_cyc);
        bool_loop: begin end
        w_n = 0; a_n = 0; c_n = 0;
        done_cyc = -1;
        start = 1'b1;
        len   = (AW+1)'(ln);
        bias  = ACCW'(bs);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            act_out_busy = (c >= st_from && c <= st_to);
            if (c == inj) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(1); wr_data = 8'd99;
                start = 1'b1; len = 5'd2;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 1) check_eq("active_run", {31'd0, active}, 32'd1);
            if (act_out_busy) begin
                check_eq("stall_act_vld", {31'd0, act_out_vld}, 32'd1);
                check_eq("stall_act_data", {24'd0, act_out_data}, 32'(stall_act));
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (weight_out_vld && !weight_out_busy && w_n < 32) begin
                w_tok[w_n] = {24'd0, weight_out_data}; w_n++;
            end
            if (act_out_vld && !act_out_busy && a_n < 32) begin
                a_tok[a_n] = {24'd0, act_out_data}; a_n++;
            end
            if (accum_out_vld && !accum_out_busy && c_n < 32) begin
                c_tok[c_n] = accum_out_data; c_n++;
            end
            tick();
        end
        act_out_busy = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        if (done_cyc < 0) begin
            check_eq("done_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check_eq("done_one_cycle", {31'd0, done}, 32'd0);
            tick();
            @(negedge clk);
            check_eq("idle_after_done", {31'd0, active}, 32'd0);
            tick();
        end
    endtask

    task automatic check_tokens(input string tag, input int n, input int bs);
        check_eq({tag, "_w_count"}, 32'(w_n), 32'(n));
        check_eq({tag, "_a_count"}, 32'(a_n), 32'(n));
        check_eq({tag, "_c_count"}, 32'(c_n), 32'(n));
        for (int i = 0; i < n && i < 32; i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), w_tok[i], w_exp[i]);
            check_eq($sformatf("%s_a%0d", tag, i), a_tok[i], a_exp[i]);
            check_eq($sformatf("%s_c%0d", tag, i), c_tok[i], 32'(bs));
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) begin
            ram_write(1'b0, i, i + 1);
            ram_write(1'b1, i, (i + 1) * 10);
            w_exp[i] = 32'(i + 1);
            a_exp[i] = 32'((i + 1) * 10);
        end
    endtask

    int dc;

    initial begin
        #12;
        @(negedge clk);
        check_eq("rst_vld", {29'd0, weight_out_vld, act_out_vld, accum_out_vld}, 32'd0);
        check_eq("rst_wdata", {24'd0, weight_out_data}, 32'd0);
        check_eq("rst_cdata", accum_out_data, 32'd0);
        check_eq("rst_done_active", {30'd0, done, active}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic burst
        load_basic();
        run_burst(4, 7, 0, -1, 0, 0, dc);
        check_tokens("basic", 4, 7);
        check_eq("basic_done_cycle", 32'(dc), 32'd5);

        // Back-pressure on act, cycles 2-5
        run_burst(4, 7, 2, 5, 20, 0, dc);
        check_tokens("bp", 4, 7);
        check_eq("bp_done_cycle", 32'(dc), 32'd9);
`ifdef SYSPE_FEEDER_STALL_CNT_EN
        check_eq("bp_stall_cnt", {16'd0, stall_cnt}, 32'd4);
`endif

        // len = 0
        start = 1'b1; len = '0; bias = 32'd5;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("len0_done", {31'd0, done}, 32'd1);
        check_eq("len0_active", {31'd0, active}, 32'd0);
        check_eq("len0_vld", {29'd0, weight_out_vld, act_out_vld, accum_out_vld}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("len0_done_drop", {31'd0, done}, 32'd0);
        tick();

        // Clamp len=31 to 16
        for (int i = 0; i < DEPTH; i++) begin
            ram_write(1'b0, i, i * 3 + 1);
            ram_write(1'b1, i, 200 - i);
            w_exp[i] = 32'(i * 3 + 1);
            a_exp[i] = 32'(200 - i);
        end
        run_burst(31, 32'h1234_5678, 0, -1, 0, 0, dc);
        check_tokens("clamp", 16, 32'h1234_5678);
        check_eq("clamp_done_cycle", 32'(dc), 32'd17);

        // Ignored write and start during RUN
        load_basic();
        run_burst(4, 3, 0, -1, 0, 2, dc);
        check_tokens("ign", 4, 3);
        run_burst(4, 3, 0, -1, 0, 0, dc);
        check_tokens("ign_next", 4, 3);

        // Reset mid-burst after two transfers
        start = 1'b1; len = 5'd4; bias = 32'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("mrst_vld", {29'd0, weight_out_vld, act_out_vld, accum_out_vld}, 32'd0);
        check_eq("mrst_data", {weight_out_data, act_out_data, 16'd0} | accum_out_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mrst_no_done", {31'd0, done}, 32'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_idle", {31'd0, active}, 32'd0);
        check_eq("mrst_no_done_after", {31'd0, done}, 32'd0);
        tick();
        load_basic();
        run_burst(4, 11, 0, -1, 0, 0, dc);
        check_tokens("post_rst", 4, 11);
        check_eq("post_rst_done_cycle", 32'(dc), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
